// File: rtl/issue_scoreboard_pkg.sv
// Shared definitions for the issue-stage scoreboard.
//   REG_W            : register index width
//   LAT_*_DEFAULT    : default ALU / load writeback latencies
//   slot_t           : one writeback schedule entry {valid, rd}
package issue_scoreboard_pkg;

  localparam int unsigned REG_W           = 5;
  localparam int unsigned LAT_ALU_DEFAULT = 2;
  localparam int unsigned LAT_MEM_DEFAULT = 4;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
  } slot_t;

endpackage

// File: rtl/wb_slot_shifter.sv
// Writeback schedule shift register.
// Every clock the entries move one slot towards slot 0 and the top slot
// empties; an optional new entry is written at a one-hot position of the
// post-shift array. Slot 0 is the write retiring in the current cycle.
// Ports:
//   clock, reset   : clock, asynchronous active-low reset
//   ins_en         : write a new entry this cycle
//   ins_pos        : one-hot post-shift position of the new entry
//   ins_reg        : destination register of the new entry
//   slot_valid     : valid flag of every slot
//   head           : slot 0 (retiring write)
module wb_slot_shifter
  import issue_scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH = LAT_MEM_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ins_en,
  input  logic [DEPTH-1:0] ins_pos,
  input  reg_idx_t         ins_reg,
  output logic [DEPTH-1:0] slot_valid,
  output slot_t            head
);

  slot_t slot_q [DEPTH];
  slot_t slot_d [DEPTH];

  always_comb begin
    for (int unsigned i = 0; i < DEPTH - 1; i++) begin
      slot_d[i] = slot_q[i+1];
    end
    slot_d[DEPTH-1] = '0;
    // The caller guarantees the target position is empty after the shift.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ins_en && ins_pos[i]) begin
        slot_d[i].valid = 1'b1;
        slot_d[i].rd    = ins_reg;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot_valid[i] = slot_q[i].valid;
    end
  end

  assign head = slot_q[0];

endmodule

// File: rtl/issue_scoreboard.sv
// Issue-stage scoreboard between decode and execute.
// Holds decode (iss_stall) on RAW, WAW or writeback-port hazards, emits a
// registered issue pulse and the writeback schedule that retires pending
// register writes.
// Optional feature: define ISS_FORWARD_EN to treat a register retiring in
// the current cycle as ready (writeback value bypassed).
// Ports:
//   clock, reset          : clock, asynchronous active-low reset
//   id_iss_*              : decoded instruction fields from decode
//   iss_stall             : combinational hold request to decode
//   iss_ex_issue          : registered issue pulse to execute
//   iss_wb_valid/_reg     : write retiring this cycle
//   iss_busy              : pending-write bitmap (bit 0 always 0)
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int unsigned LAT_ALU = LAT_ALU_DEFAULT,
  parameter int unsigned LAT_MEM = LAT_MEM_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_iss_valid,
  input  logic [REG_W-1:0] id_iss_addra,
  input  logic [REG_W-1:0] id_iss_addrb,
  input  logic             id_iss_usea,
  input  logic             id_iss_useb,
  input  logic [REG_W-1:0] id_iss_regdest,
  input  logic             id_iss_writereg,
  input  logic             id_iss_readmem,
  output logic             iss_stall,
  output logic             iss_ex_issue,
  output logic             iss_wb_valid,
  output logic [REG_W-1:0] iss_wb_reg,
  output logic [31:0]      iss_busy
);

  // Post-shift insert positions, and the slot an ALU write would collide
  // with (none when both latencies are equal).
  localparam logic [LAT_MEM-1:0] ALU_POS  = LAT_MEM'(1) << (LAT_ALU - 1);
  localparam logic [LAT_MEM-1:0] MEM_POS  = LAT_MEM'(1) << (LAT_MEM - 1);
  localparam logic [LAT_MEM-1:0] PORT_CHK = (LAT_ALU < LAT_MEM) ?
                                            (LAT_MEM'(1) << LAT_ALU) : '0;

  logic [31:0]        busy_q, busy_d;
  logic               issue_q, issue_d;
  logic [LAT_MEM-1:0] slot_valid;
  slot_t              head;
  logic               fwd_valid;
  logic               raw, waw, port, issue, alloc;

`ifdef ISS_FORWARD_EN
  assign fwd_valid = head.valid;
`else
  assign fwd_valid = 1'b0;
`endif

  function automatic logic src_ready(input reg_idx_t    r,
                                     input logic [31:0] busy,
                                     input logic        fv,
                                     input reg_idx_t    fr);
    return (r == '0) || !busy[r] || (fv && (fr == r));
  endfunction

  wb_slot_shifter #(.DEPTH(LAT_MEM)) u_shifter (
    .clock      (clock),
    .reset      (reset),
    .ins_en     (alloc),
    .ins_pos    (id_iss_readmem ? MEM_POS : ALU_POS),
    .ins_reg    (id_iss_regdest),
    .slot_valid (slot_valid),
    .head       (head)
  );

  always_comb begin
    raw = (id_iss_usea && !src_ready(id_iss_addra, busy_q, fwd_valid, head.rd)) ||
          (id_iss_useb && !src_ready(id_iss_addrb, busy_q, fwd_valid, head.rd));
    waw = id_iss_writereg && (id_iss_regdest != '0) &&
          !src_ready(id_iss_regdest, busy_q, fwd_valid, head.rd);
    // Loads use the top slot, which is always empty after the shift.
    port = id_iss_writereg && !id_iss_readmem && (|(slot_valid & PORT_CHK));
    iss_stall = id_iss_valid && (raw || waw || port);
    issue     = id_iss_valid && !iss_stall;
    alloc     = issue && id_iss_writereg && (id_iss_regdest != '0);

    busy_d = busy_q;
    if (head.valid) busy_d[head.rd] = 1'b0;
    // Set after clear so a same-cycle set wins.
    if (alloc) busy_d[id_iss_regdest] = 1'b1;
    busy_d[0] = 1'b0;

    issue_d = issue;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q  <= '0;
      issue_q <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      issue_q <= issue_d;
    end
  end

  assign iss_ex_issue = issue_q;
  assign iss_wb_valid = head.valid;
  assign iss_wb_reg   = head.rd;
  assign iss_busy     = busy_q;

endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

Issue-stage scoreboard between decode and execute. Tracks every in-flight register write and holds decode, via `iss_stall`, until three conditions hold: source operands are ready, the destination has no pending write (WAW), and the single register-file write port is free in the writeback cycle. Produces the registered issue pulse to execute and the writeback schedule used to retire pending writes.

## Interface
Parameters:
- `LAT_ALU`, default 2: cycles from issue to writeback for ALU/shift instructions (≥1).
- `LAT_MEM`, default 4: cycles from issue to writeback for loads (≥`LAT_ALU`).

Ports:
- `clock`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-low
- `id_iss_valid`  in  1  decode presents an instruction
- `id_iss_addra`  in  5  rs source register
- `id_iss_addrb`  in  5  rt source register
- `id_iss_usea`  in  1  instruction reads rs
- `id_iss_useb`  in  1  instruction reads rt (R-type or store)
- `id_iss_regdest`  in  5  destination register
- `id_iss_writereg`  in  1  instruction writes the register file
- `id_iss_readmem`  in  1  instruction is a load (uses `LAT_MEM`)
- `iss_stall`  out  1  combinational; decode must hold its instruction
- `iss_ex_issue`  out  1  registered one-cycle pulse: instruction issued
- `iss_wb_valid`  out  1  a write retires this cycle
- `iss_wb_reg`  out  5  register retiring this cycle
- `iss_busy`  out  32  pending-write bitmap (bit 0 always 0)

## Operation
- State: `busy[31:0]` and writeback shift register `slot[0..LAT_MEM-1]`, each entry {valid, reg[4:0]}. `iss_wb_valid`/`iss_wb_reg` = `slot[0]`.
- Each clock: `slot[i] <= slot[i+1]`, and the top slot becomes invalid. If `slot[0].valid`, clear `busy[slot[0].reg]`.
- Latency selection: L = `LAT_MEM` if `id_iss_readmem`, else `LAT_ALU`.
- Source `r` is ready when any of these holds:
  - `r==0`
  - `!busy[r]`
  - the forwarding term described under Configuration applies.
- Hazards:
  - RAW: `usea && !ready(addra)`, or `useb && !ready(addrb)`.
  - WAW: `writereg && regdest!=0 && !ready(regdest)`.
  - Port conflict: `writereg && L<LAT_MEM && slot[L].valid`. That entry would land in `slot[L-1]` after the shift, so the new write would collide with it.
- `iss_stall = id_iss_valid && (RAW || WAW || port)`.
- Issue fires when `id_iss_valid && !iss_stall`. On issue:
  - `iss_ex_issue <= 1`.
  - If `writereg && regdest!=0`: `slot[L-1] <= {1, regdest}` after the shift, and `busy[regdest] <= 1`.
- Simultaneous set and clear of the same `busy` bit in one cycle: set wins.
- Writes to `$0` never occupy a slot and never set `busy`.
- No `writereg` (stores, branches): the instruction issues without any slot use.

## Timing
- Reset, asynchronous and asserted low, forces:
  - all slots invalid and `busy=0`;
  - `iss_ex_issue=0`, `iss_wb_valid=0`, `iss_wb_reg=0`, `iss_busy=0`;
  - `iss_stall=0` while `id_iss_valid=0`.
- Reset mid-operation discards all pending writes; no writeback is reported afterwards.
- An instruction issued at edge N appears on `iss_wb_valid` during cycle N+L−1 → N+L. Its `busy` bit clears at edge N+L.
- `iss_stall` is purely combinational from inputs and state, with no added latency. Decode holds its inputs stable while stalled.
- Throughput: one issue per cycle when there are no hazards.

## Configuration
- `ISS_FORWARD_EN` defined: `ready(r)` is also true when `slot[0].valid && slot[0].reg==r`. A dependent instruction then issues in the retiring cycle, since the writeback value is bypassed.
- Undefined: the dependent instruction waits until the `busy` bit has cleared, one cycle later. Back-to-back ALU dependence then costs `LAT_ALU` stall cycles instead of `LAT_ALU−1`.

## Structure
- Shared package holds:
  - the `LAT_ALU`/`LAT_MEM` defaults;
  - the slot entry typedef {valid, reg[4:0]};
  - the register index width of 5.
- One sub-module, `wb_slot_shifter`: the parameterised writeback shift register with insert-at-position, exposing slot `valid` flags and `slot[0]`. The scoreboard owns the busy bitmap and hazard logic.

## Test plan
- Independent ALU writes to r1, r2, r3 on consecutive cycles → no stall; `iss_wb_reg` = 1, 2, 3 on consecutive cycles, starting 2 cycles after the first issue.
- `add r4` then `add r5,r4,r4` (usea/useb on r4) with `LAT_ALU=2`:
  - forwarding undefined → `iss_stall` high for 2 cycles;
  - with `ISS_FORWARD_EN` → stall for 1 cycle.
- Load r6 (`LAT_MEM=4`) issued, then an ALU write r7 two cycles later → port conflict; `iss_stall` high for 1 cycle, with r6 and r7 retiring on distinct cycles.
- Load r8 followed by an ALU write to r8 → WAW stall until `busy[8]` clears; `iss_busy[8]` drops exactly once.
- Write to r0 with `usea` on r0 → never stalls; `iss_busy` stays 0 and `iss_wb_valid` stays 0.
- Reset asserted while loads to r9/r10 are in flight → `busy=0` and all slots empty immediately; no `iss_wb_valid` after release.
